// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB4 slave bridging to the UART register block
// through a one-cycle request / acknowledge handshake.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   psel/penable/pwrite : APB4 control
//   paddr/pwdata/pstrb  : APB4 address, write data, byte strobes
//   pready/pslverr      : registered completion and error response
//   prdata              : registered read data (0 unless good read)
//   reg_req/reg_we      : register access request (1 cycle), write
//   reg_addr/reg_wdata  : word-aligned address, write data
//   reg_wstrb           : byte enables (0 on reads)
//   reg_ack/reg_rdata   : register block done, read data
//   reg_err             : register decode error, valid with reg_ack
//
// Optional: define APB_REG_BRIDGE_TIMEOUT_EN to error out an access
// when reg_ack is missing TIMEOUT cycles after reg_req.
module apb_reg_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic                pslverr,
    output logic [DATA_W-1:0]   prdata,
    output logic                reg_req,
    output logic                reg_we,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W/8-1:0] reg_wstrb,
    input  logic                reg_ack,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic                reg_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("apb_reg_bridge: TIMEOUT must be 1..255");
    end
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64)
    begin : g_bad_data_w
        $error("apb_reg_bridge: DATA_W must be 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mis;
    logic                r_noop;
    logic                r_pready;
    logic                r_pslverr;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic                w_setup;
    logic                w_misaligned;
    logic                w_noop;
    logic                w_flag;
    logic                w_ack;
    logic                w_tmo;
    logic                w_done;
    logic                w_err;
    logic                w_resp;
    logic [DATA_W-1:0]   w_prdata_nxt;

    assign w_setup      = (r_state == S_IDLE) & psel & ~penable;
    assign w_misaligned = |(paddr & ALIGN_MASK);
    assign w_noop       = pwrite & ~|pstrb;

    // Flagged transfers never issue a request, so any reg_ack seen
    // while they sit in ACCESS belongs to nobody and is ignored.
    assign w_flag = r_mis | r_noop;
    assign w_ack  = (r_state == S_ACCESS) & ~w_flag & reg_ack;

`ifdef APB_REG_BRIDGE_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Counter is 0 in the reg_req cycle; an ack in the expiry cycle
    // takes priority over the timeout.
    assign w_tmo = (r_state == S_ACCESS) & ~w_flag & ~reg_ack
                 & (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_ACCESS && !w_done) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_done = (r_state == S_ACCESS) & (w_flag | reg_ack | w_tmo);
    assign w_err  = r_mis | w_tmo | (w_ack & reg_err);

    // The response is decided on the ACCESS->RESP edge so pready is a
    // plain flop; a master that dropped psel gets nothing.
    assign w_resp = w_done & psel & penable;

    always_comb begin
        w_state_nxt  = r_state;
        w_prdata_nxt = '0;
        if (w_resp && !r_we && !w_err) begin
            w_prdata_nxt = reg_rdata;
        end
        unique case (r_state)
            S_IDLE:   if (w_setup) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_done)  w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mis     <= 1'b0;
            r_noop    <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= 1'b0;
            r_pready  <= w_resp;
            r_pslverr <= w_resp & w_err;
            r_prdata  <= w_prdata_nxt;
            if (w_setup) begin
                r_mis   <= w_misaligned;
                r_noop  <= w_noop;
                r_req   <= ~w_misaligned & ~w_noop;
                r_we    <= pwrite;
                r_addr  <= paddr & ~ALIGN_MASK;
                r_wdata <= pwdata;
                r_wstrb <= pwrite ? pstrb : '0;
            end
        end
    end

    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign prdata    = r_prdata;
    assign reg_req   = r_req;
    assign reg_we    = r_we;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wstrb = r_wstrb;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge: directed self-checking bench for apb_reg_bridge.
// Honours APB_REG_BRIDGE_TIMEOUT_EN for the timeout scenario.
module tb_apb_reg_bridge;

    logic        clk;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        reg_req;
    logic        reg_we;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;

    int n_cmp = 0;
    int n_bad = 0;

    int          o_req_cyc;
    int          o_req_cnt;
    int          o_rdy_cyc;
    int          o_stray;
    int          o_idle_hits;
    logic        o_err;
    logic        o_we;
    logic [31:0] o_rdata;
    logic [31:0] o_wdata;
    logic [11:0] o_addr;
    logic [3:0]  o_wstrb;

    apb_reg_bridge #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .reg_err   (reg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One APB transfer; cycle 0 is SETUP. The register side acks in
    // cycle 1+dly when use_ack is set, else drives garbage.
    task automatic xfer(input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input bit use_ack, input int dly,
                        input logic [31:0] rd, input logic rerr);
        o_req_cyc = -1;
        o_req_cnt = 0;
        o_rdy_cyc = -1;
        o_stray   = 0;
        o_err     = 1'bx;
        o_rdata   = 'x;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            psel    = 1'b1;
            penable = (k != 0);
            pwrite  = wr;
            paddr   = a;
            pwdata  = wd;
            pstrb   = st;
            if (use_ack && k == 1 + dly) begin
                reg_ack   = 1'b1;
                reg_rdata = rd;
                reg_err   = rerr;
            end else begin
                reg_ack   = 1'b0;
                reg_rdata = 32'hFFFF_FFFF;
                reg_err   = 1'b1;
            end
            @(negedge clk);
            if (reg_req === 1'b1) begin
                o_req_cnt++;
                if (o_req_cyc < 0) begin
                    o_req_cyc = k;
                    o_addr    = reg_addr;
                    o_wdata   = reg_wdata;
                    o_wstrb   = reg_wstrb;
                    o_we      = reg_we;
                end
            end
            if (pready === 1'b1) begin
                o_rdy_cyc = k;
                o_err     = pslverr;
                o_rdata   = prdata;
                break;
            end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
                o_stray++;
            end
        end
    endtask

    task automatic idle(input int n);
        o_idle_hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel      = 1'b0;
            penable   = 1'b0;
            reg_ack   = 1'b0;
            reg_err   = 1'b0;
            reg_rdata = 32'h0;
            @(negedge clk);
            if (pready !== 1'b0 || reg_req !== 1'b0 ||
                pslverr !== 1'b0 || prdata !== 32'h0)
                o_idle_hits++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_resp: got %b%b want 00", pready, pslverr);
        end
        n_cmp++;
        if (reg_req !== 1'b0 || reg_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_req: got %b%b want 00", reg_req, reg_we);
        end
        n_cmp++;
        if (prdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_prdata: got %h want 0", prdata);
        end
        n_cmp++;
        if ({reg_addr, reg_wdata, reg_wstrb} !== 48'h0) begin
            n_bad++;
            $display("FAIL rst_reg: got %h %h %h want 0",
                     reg_addr, reg_wdata, reg_wstrb);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write();
        xfer(1'b1, 12'h004, 32'hA5A5_1234, 4'b0011, 1'b1, 0, 32'h0, 1'b0);
        n_cmp++;
        if (o_req_cyc !== 1 || o_req_cnt !== 1) begin
            n_bad++;
            $display("FAIL wr_req: got cyc %0d cnt %0d want 1 1",
                     o_req_cyc, o_req_cnt);
        end
        n_cmp++;
        if (o_wstrb !== 4'b0011 || o_addr !== 12'h004 || o_we !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_bus: got %b %h %b want 0011 004 1",
                     o_wstrb, o_addr, o_we);
        end
        n_cmp++;
        if (o_wdata !== 32'hA5A5_1234) begin
            n_bad++;
            $display("FAIL wr_wdata: got %h want a5a51234", o_wdata);
        end
        n_cmp++;
        if (o_rdy_cyc !== 2 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rdy: got cyc %0d err %b want 2 0",
                     o_rdy_cyc, o_err);
        end
        idle(2);
        n_cmp++;
        if (o_idle_hits !== 0) begin
            n_bad++;
            $display("FAIL wr_one_rdy: got %0d hits want 0", o_idle_hits);
        end
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 12'h008, 32'h0, 4'hF, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
        n_cmp++;
        if (o_req_cyc !== 1 || o_wstrb !== 4'h0 || o_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_req: got cyc %0d strb %b we %b want 1 0000 0",
                     o_req_cyc, o_wstrb, o_we);
        end
        n_cmp++;
        if (o_rdy_cyc !== 5 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_rdy: got cyc %0d err %b want 5 0",
                     o_rdy_cyc, o_err);
        end
        n_cmp++;
        if (o_rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL rd_data: got %h want deadbeef", o_rdata);
        end
        n_cmp++;
        if (o_stray !== 0) begin
            n_bad++;
            $display("FAIL rd_stray: got %0d want 0", o_stray);
        end
        idle(2);
        n_cmp++;
        if (o_idle_hits !== 0) begin
            n_bad++;
            $display("FAIL rd_after: got %0d hits want 0", o_idle_hits);
        end
    endtask

    task automatic test_misaligned();
        xfer(1'b1, 12'h006, 32'h1111_2222, 4'hF, 1'b0, 0, 32'h0, 1'b0);
        n_cmp++;
        if (o_req_cnt !== 0) begin
            n_bad++;
            $display("FAIL mis_req: got %0d reqs want 0", o_req_cnt);
        end
        n_cmp++;
        if (o_rdy_cyc !== 2 || o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_rdy: got cyc %0d err %b want 2 1",
                     o_rdy_cyc, o_err);
        end
        idle(1);
    endtask

    task automatic test_noop();
        xfer(1'b1, 12'h00C, 32'h3333_4444, 4'h0, 1'b0, 0, 32'h0, 1'b0);
        n_cmp++;
        if (o_req_cnt !== 0) begin
            n_bad++;
            $display("FAIL noop_req: got %0d reqs want 0", o_req_cnt);
        end
        n_cmp++;
        if (o_rdy_cyc !== 2 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL noop_rdy: got cyc %0d err %b want 2 0",
                     o_rdy_cyc, o_err);
        end
        idle(1);
    endtask

    task automatic test_read_err();
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b1, 1, 32'h1234_5678, 1'b1);
        n_cmp++;
        if (o_rdy_cyc !== 3 || o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL rerr_rdy: got cyc %0d err %b want 3 1",
                     o_rdy_cyc, o_err);
        end
        n_cmp++;
        if (o_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rerr_data: got %h want 0", o_rdata);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int rdy1;
        xfer(1'b1, 12'h030, 32'h0BAD_0001, 4'hF, 1'b1, 0, 32'h0, 1'b0);
        rdy1 = o_rdy_cyc;
        xfer(1'b0, 12'h034, 32'h0, 4'h0, 1'b1, 0, 32'hCAFE_F00D, 1'b0);
        n_cmp++;
        if (rdy1 !== 2 || o_req_cyc !== 1 || o_rdy_cyc !== 2) begin
            n_bad++;
            $display("FAIL b2b_timing: got %0d %0d %0d want 2 1 2",
                     rdy1, o_req_cyc, o_rdy_cyc);
        end
        n_cmp++;
        if (o_rdata !== 32'hCAFE_F00D || o_addr !== 12'h034) begin
            n_bad++;
            $display("FAIL b2b_data: got %h @%h want cafef00d @034",
                     o_rdata, o_addr);
        end
        idle(1);
    endtask

    task automatic test_psel_drop();
        int   hits;
        logic seen_req;
        hits = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h014; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        reg_ack = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        seen_req = reg_req;
        @(posedge clk); #1;
        reg_ack = 1'b1; reg_err = 1'b0;
        @(negedge clk);
        if (pready !== 1'b0) hits++;
        @(posedge clk); #1;
        reg_ack = 1'b0;
        @(negedge clk);
        if (pready !== 1'b0) hits++;
        idle(3);
        hits += o_idle_hits;
        @(posedge clk); #1;
        reg_ack = 1'b1; reg_err = 1'b1;
        @(negedge clk);
        if (pready !== 1'b0 || reg_req !== 1'b0) hits++;
        idle(2);
        hits += o_idle_hits;
        n_cmp++;
        if (seen_req !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_req: got %b want 1", seen_req);
        end
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL drop_rdy: got %0d hits want 0", hits);
        end
        xfer(1'b0, 12'h018, 32'h0, 4'h0, 1'b1, 0, 32'h5A5A_5A5A, 1'b0);
        n_cmp++;
        if (o_rdy_cyc !== 2 || o_rdata !== 32'h5A5A_5A5A) begin
            n_bad++;
            $display("FAIL drop_recover: got cyc %0d %h want 2 5a5a5a5a",
                     o_rdy_cyc, o_rdata);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic seen_req;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h020; pwdata = 32'h0000_0077; pstrb = 4'hF;
        reg_ack = 1'b0; reg_err = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        seen_req = reg_req;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        reg_ack = 1'b1; reg_rdata = 32'h1111_1111;
        @(negedge clk);
        n_cmp++;
        if (seen_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_req: got %b want 1", seen_req);
        end
        n_cmp++;
        if ({pready, pslverr, reg_req, reg_we} !== 4'b0 ||
            {prdata, reg_addr, reg_wdata, reg_wstrb} !== 80'h0) begin
            n_bad++;
            $display("FAIL rmid_out: got %b%b%b%b %h %h %h %h want 0",
                     pready, pslverr, reg_req, reg_we,
                     prdata, reg_addr, reg_wdata, reg_wstrb);
        end
        idle(3);
        n_cmp++;
        if (o_idle_hits !== 0) begin
            n_bad++;
            $display("FAIL rmid_late: got %0d hits want 0", o_idle_hits);
        end
    endtask

    task automatic test_timeout();
`ifdef APB_REG_BRIDGE_TIMEOUT_EN
        xfer(1'b0, 12'h040, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0);
        n_cmp++;
        if (o_req_cyc !== 1 || o_rdy_cyc !== 16) begin
            n_bad++;
            $display("FAIL tmo_rdy: got req %0d rdy %0d want 1 16",
                     o_req_cyc, o_rdy_cyc);
        end
        n_cmp++;
        if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL tmo_err: got %b %h want 1 0", o_err, o_rdata);
        end
        idle(1);
        xfer(1'b0, 12'h044, 32'h0, 4'h0, 1'b1, 14, 32'h600D_F00D, 1'b0);
        n_cmp++;
        if (o_rdy_cyc !== 16 || o_err !== 1'b0 ||
            o_rdata !== 32'h600D_F00D) begin
            n_bad++;
            $display("FAIL tmo_race: got %0d %b %h want 16 0 600df00d",
                     o_rdy_cyc, o_err, o_rdata);
        end
`else
        xfer(1'b0, 12'h040, 32'h0, 4'h0, 1'b1, 20, 32'h600D_F00D, 1'b0);
        n_cmp++;
        if (o_rdy_cyc !== 22 || o_err !== 1'b0 ||
            o_rdata !== 32'h600D_F00D) begin
            n_bad++;
            $display("FAIL long_wait: got %0d %b %h want 22 0 600df00d",
                     o_rdy_cyc, o_err, o_rdata);
        end
`endif
        n_cmp++;
        if (o_stray !== 0) begin
            n_bad++;
            $display("FAIL wait_stray: got %0d want 0", o_stray);
        end
        idle(1);
    endtask

    initial begin
        reset     = 1'b1;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 12'h0;
        pwdata    = 32'h0;
        pstrb     = 4'h0;
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        reg_err   = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_misaligned();
        test_noop();
        test_read_err();
        test_back_to_back();
        test_psel_drop();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
